alu_muldiv_unit: RTL and testbench
==================================

ALU_MULDIV_UNIT -- requirements
Module: alu_muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width (power of two, >= 8).
REQ-002 SHALL have parameter MULDIV_EN, default 1; 0 removes M-extension decode, and M-encodings execute as base ops.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, the request handshake.
REQ-006 SHALL have ports ALUOp input 2, funct3 input 3, funct7b5 input 1, funct7b0 input 1 and opb5 input 1, the decode fields.
REQ-007 SHALL have ports src_a input XLEN and src_b input XLEN, the operands.
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1, the response handshake.
REQ-009 SHALL have ports result output XLEN, zero output 1 (result==0) and busy output 1 (an iterative op is in progress).

Function
REQ-010 SHALL accept a request when in_valid && in_ready, capturing all inputs that cycle.
REQ-011 SHALL decode ALUOp 00 -> add and ALUOp 01 -> sub (A-B); ALUOp 1x decodes via funct3.
REQ-012 For ALUOp 1x, funct3 SHALL decode as follows:
- 000: sub if funct7b5&opb5, else add.
- 001: sll.
- 010: slt (signed).
- 011: sltu (unsigned).
- 100: xor.
- 101: sra if funct7b5, else srl.
- 110: or.
- 111: and.
REQ-013 Shift amount SHALL be src_b[log2(XLEN)-1:0]; slt/sltu SHALL return zero-extended 0/1.
REQ-014 M-op SHALL be decoded when MULDIV_EN && ALUOp==10 && opb5 && funct7b0, and SHALL take precedence over REQ-012.
REQ-015 M-op funct3 SHALL decode as follows:
- 000: mul (low XLEN).
- 001: mulh (s*s, high).
- 010: mulhsu (s*u, high).
- 011: mulhu (high).
- 100: div.
- 101: divu.
- 110: rem.
- 111: remu.
REQ-016 SHALL use states IDLE, MUL, DIV, DONE.
REQ-017 Accepting a base op SHALL go to DONE with the result registered, so out_valid rises the next cycle (latency 1).
REQ-018 Accepting a mul SHALL go to MUL for exactly XLEN cycles (one shift-add per cycle on 2*XLEN-bit product, sign-corrected per REQ-015), then DONE (latency XLEN+1).
REQ-019 Accepting a div/rem SHALL go to DIV for exactly XLEN cycles (restoring, on magnitudes; quotient sign = sign(A) xor sign(B); remainder sign = sign(A)), then DONE (latency XLEN+1).
REQ-020 Division by zero SHALL skip DIV with latency 1, giving quotient all-ones and remainder = src_a.
REQ-021 Signed overflow (src_a = -2^(XLEN-1), src_b = -1) SHALL skip DIV with latency 1, giving quotient = src_a and remainder 0.
REQ-022 in_ready SHALL be 1 in IDLE, or in DONE when out_ready is 1 (back-to-back issue), and 0 otherwise.
REQ-023 In DONE, out_valid SHALL be 1, and result/zero SHALL hold stable until out_ready.
REQ-024 In DONE, out_ready with no new request SHALL go to IDLE; out_ready together with a new accept SHALL take the new op's path.
REQ-025 busy SHALL be 1 exactly in MUL and DIV.
REQ-026 in_valid during MUL/DIV SHALL be ignored and SHALL NOT be captured.
REQ-027 All arithmetic SHALL wrap modulo 2^XLEN; no overflow flag.

Reset
REQ-028 reset SHALL force state IDLE and set out_valid=0, busy=0, result=0, zero=0, with in_ready=1 the cycle after reset deasserts.
REQ-029 reset asserted mid-MUL/DIV SHALL abort the op, discard partial state, and produce no out_valid.

Verification
REQ-030 (XLEN=32) ALUOp=10, funct3=000, opb5=1, funct7b5=1, funct7b0=0, A=5, B=7 -> out_valid next cycle, result=0xFFFFFFFE, zero=0.
REQ-031 funct3=101, funct7b5=1, A=0x80000000, B=4 -> result 0xF8000000; with funct7b5=0 -> 0x08000000.
REQ-032 mulh, A=0xFFFFFFFF, B=2 -> busy for 32 cycles, out_valid at accept+33, result=0xFFFFFFFF.
REQ-033 div A=7, B=0 -> result 0xFFFFFFFF at accept+1; rem A=0x80000000, B=0xFFFFFFFF -> result 0 at accept+1.
REQ-034 divu A=100, B=7 held with out_ready=0 for 5 cycles after out_valid -> result stays 14 and in_ready stays 0 throughout; on release, a back-to-back add is accepted the same cycle.
REQ-035 reset pulsed at cycle 10 of a mul -> out_valid never asserts, IDLE/in_ready=1 the next cycle, and a following sltu A=1, B=0xFFFFFFFF gives result 1.

Source files
------------

// File: rtl/alu_muldiv_unit_if.sv
// Request/response bundle for alu_muldiv_unit.
//   master : issues requests (in_valid, decode fields, operands) and
//            accepts responses (out_ready).
//   slave  : the execution unit; returns in_ready, out_valid, result,
//            zero and busy.
// The decode field ALUOp keeps its established mixed-case name so it
// lines up with the surrounding core decoder.
interface alu_muldiv_unit_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      ALUOp;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            funct7b0;
    logic            opb5;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    modport master (
        output in_valid, ALUOp, funct3, funct7b5, funct7b0, opb5,
               src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, ALUOp, funct3, funct7b5, funct7b0, opb5,
               src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/alu_muldiv_unit.sv
// Integer ALU with optional iterative multiply/divide.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : request/response bundle (slave side), see alu_muldiv_unit_if
// Base ops complete in one cycle. Multiplies run an XLEN-cycle shift-add
// on operand magnitudes; divides run an XLEN-cycle restoring division on
// magnitudes. Signs are applied when the final iteration retires.
module alu_muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int MULDIV_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    alu_muldiv_unit_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);
    localparam logic [SHW-1:0]  CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
    typedef enum logic [1:0] {L_BASE = 2'd0, L_MUL = 2'd1, L_DIV = 2'd2} launch_t;

    state_t            state_r;
    logic [2*XLEN-1:0] acc_r;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   opnd_r;     // multiplicand or divisor magnitude
    logic [SHW-1:0]    cnt_r;
    logic              sel_r;      // mul: take high half; div: take remainder
    logic              neg_r;      // negate the final value
    logic [XLEN-1:0]   result_r;
    logic              zero_r;
    logic              out_valid_r;
    logic              busy_r;

    logic              accept_s;
    logic              in_ready_s;
    logic              is_m_s;
    logic [SHW-1:0]    shamt_s;
    logic [XLEN-1:0]   base_res_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    launch_t           launch_s;
    logic [XLEN-1:0]   imm_res_s;
    logic [2*XLEN-1:0] init_acc_s;
    logic [XLEN-1:0]   init_opnd_s;
    logic              init_sel_s;
    logic              init_neg_s;

    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] mul_next_s;
    logic [2*XLEN-1:0] mul_signed_s;
    logic [XLEN-1:0]   mul_res_s;
    logic [XLEN:0]     rem_sh_s;
    logic [XLEN:0]     rem_diff_s;
    logic              rem_ge_s;
    logic [2*XLEN-1:0] div_next_s;
    logic [XLEN-1:0]   div_val_s;
    logic [XLEN-1:0]   div_res_s;

    // Back-to-back issue is allowed while the current response is consumed.
    assign in_ready_s = (state_r == IDLE) || ((state_r == DONE) && bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign is_m_s     = (MULDIV_EN != 0) && (bus.ALUOp == 2'b10) && bus.opb5 && bus.funct7b0;
    assign shamt_s    = bus.src_b[SHW-1:0];

    // Base ALU result and launch decode for the request presented this cycle.
    always_comb begin
        base_res_s  = '0;
        a_neg_s     = 1'b0;
        b_neg_s     = 1'b0;
        launch_s    = L_BASE;
        imm_res_s   = '0;
        init_acc_s  = '0;
        init_opnd_s = '0;
        init_sel_s  = 1'b0;
        init_neg_s  = 1'b0;

        case (bus.ALUOp)
            2'b00: base_res_s = bus.src_a + bus.src_b;
            2'b01: base_res_s = bus.src_a - bus.src_b;
            default: begin
                case (bus.funct3)
                    3'b000: begin
                        if (bus.funct7b5 && bus.opb5) begin
                            base_res_s = bus.src_a - bus.src_b;
                        end else begin
                            base_res_s = bus.src_a + bus.src_b;
                        end
                    end
                    3'b001: base_res_s = bus.src_a << shamt_s;
                    3'b010: base_res_s = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
                    3'b011: base_res_s = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
                    3'b100: base_res_s = bus.src_a ^ bus.src_b;
                    3'b101: begin
                        if (bus.funct7b5) begin
                            base_res_s = $signed(bus.src_a) >>> shamt_s;
                        end else begin
                            base_res_s = bus.src_a >> shamt_s;
                        end
                    end
                    3'b110: base_res_s = bus.src_a | bus.src_b;
                    3'b111: base_res_s = bus.src_a & bus.src_b;
                    default: base_res_s = '0;
                endcase
            end
        endcase

        // Operand signedness: mulh s*s, mulhsu s*u, div/rem signed.
        if (!bus.funct3[2]) begin
            a_neg_s = ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b010)) && bus.src_a[XLEN-1];
            b_neg_s = (bus.funct3 == 3'b001) && bus.src_b[XLEN-1];
        end else begin
            a_neg_s = !bus.funct3[0] && bus.src_a[XLEN-1];
            b_neg_s = !bus.funct3[0] && bus.src_b[XLEN-1];
        end
        a_mag_s = a_neg_s ? (~bus.src_a + {{(XLEN-1){1'b0}}, 1'b1}) : bus.src_a;
        b_mag_s = b_neg_s ? (~bus.src_b + {{(XLEN-1){1'b0}}, 1'b1}) : bus.src_b;

        if (!is_m_s) begin
            imm_res_s = base_res_s;
        end else if (!bus.funct3[2]) begin
            launch_s    = L_MUL;
            init_acc_s  = {{XLEN{1'b0}}, b_mag_s};
            init_opnd_s = a_mag_s;
            init_sel_s  = (bus.funct3 != 3'b000);
            init_neg_s  = a_neg_s ^ b_neg_s;
        end else if (bus.src_b == '0) begin
            imm_res_s = bus.funct3[1] ? bus.src_a : ALL_ONES;
        end else if (!bus.funct3[0] && (bus.src_a == MIN_NEG) && (bus.src_b == ALL_ONES)) begin
            imm_res_s = bus.funct3[1] ? {XLEN{1'b0}} : bus.src_a;
        end else begin
            launch_s    = L_DIV;
            init_acc_s  = {{XLEN{1'b0}}, a_mag_s};
            init_opnd_s = b_mag_s;
            init_sel_s  = bus.funct3[1];
            init_neg_s  = bus.funct3[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
        end
    end

    // One shift-add step and one restoring-division step, plus final signing.
    always_comb begin
        mul_sum_s    = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        mul_next_s   = {mul_sum_s, acc_r[XLEN-1:1]};
        mul_signed_s = neg_r ? (~mul_next_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : mul_next_s;
        mul_res_s    = sel_r ? mul_signed_s[2*XLEN-1:XLEN] : mul_signed_s[XLEN-1:0];

        rem_sh_s   = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        rem_diff_s = rem_sh_s - {1'b0, opnd_r};
        rem_ge_s   = (rem_sh_s >= {1'b0, opnd_r});
        // The partial remainder always stays below the divisor, so XLEN bits hold it.
        if (rem_ge_s) begin
            div_next_s = {rem_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        end else begin
            div_next_s = {rem_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
        end
        div_val_s = sel_r ? div_next_s[2*XLEN-1:XLEN] : div_next_s[XLEN-1:0];
        div_res_s = neg_r ? (~div_val_s + {{(XLEN-1){1'b0}}, 1'b1}) : div_val_s;
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            opnd_r      <= '0;
            cnt_r       <= '0;
            sel_r       <= 1'b0;
            neg_r       <= 1'b0;
            result_r    <= '0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        acc_r  <= init_acc_s;
                        opnd_r <= init_opnd_s;
                        sel_r  <= init_sel_s;
                        neg_r  <= init_neg_s;
                        cnt_r  <= CNT_LAST;
                        case (launch_s)
                            L_MUL: begin
                                state_r     <= MUL;
                                out_valid_r <= 1'b0;
                                busy_r      <= 1'b1;
                            end
                            L_DIV: begin
                                state_r     <= DIV;
                                out_valid_r <= 1'b0;
                                busy_r      <= 1'b1;
                            end
                            default: begin
                                state_r     <= DONE;
                                result_r    <= imm_res_s;
                                zero_r      <= (imm_res_s == '0);
                                out_valid_r <= 1'b1;
                                busy_r      <= 1'b0;
                            end
                        endcase
                    end else if ((state_r == DONE) && bus.out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                MUL: begin
                    acc_r <= mul_next_s;
                    if (cnt_r == '0) begin
                        state_r     <= DONE;
                        result_r    <= mul_res_s;
                        zero_r      <= (mul_res_s == '0);
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                DIV: begin
                    acc_r <= div_next_s;
                    if (cnt_r == '0) begin
                        state_r     <= DONE;
                        result_r    <= div_res_s;
                        zero_r      <= (div_res_s == '0);
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed self-checking bench for alu_muldiv_unit (XLEN=32).
module tb_alu_muldiv_unit;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_muldiv_unit_if #(.XLEN(32)) bus ();

    alu_muldiv_unit #(.XLEN(32), .MULDIV_EN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7b5,
                         input logic f7b0, input logic opb5, input logic [31:0] a,
                         input logic [31:0] b);
        bus.ALUOp    = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7b5;
        bus.funct7b0 = f7b0;
        bus.opb5     = opb5;
        bus.src_a    = a;
        bus.src_b    = b;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7b5,
                         input logic f7b0, input logic opb5, input logic [31:0] a,
                         input logic [31:0] b);
        drive(op, f3, f7b5, f7b0, opb5, a, b);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Issue one op, measure latency and busy cycles, then check the response.
    // With poke set, in_valid is raised for a few cycles mid-operation.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic f7b5, input logic f7b0, input logic opb5,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp, input bit poke);
        int lat;
        int busy_n;
        issue(op, f3, f7b5, f7b0, opb5, a, b);
        lat    = 1;
        busy_n = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) busy_n++;
            bus.in_valid = poke && (lat <= 4);
            @(posedge clk);
            #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy_cycles"}, busy_n, exp_lat - 1);
        check({tag, " result"}, bus.result, exp);
        check({tag, " zero"}, {31'd0, bus.zero}, {31'd0, (exp == 32'd0)});
    endtask

    initial begin
        int lat;
        int seen;
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst busy",      {31'd0, bus.busy},      32'd0);
        check("rst result",    bus.result,             32'd0);
        check("rst zero",      {31'd0, bus.zero},      32'd0);
        check("rst in_ready",  {31'd0, bus.in_ready},  32'd1);

        // Base ops, latency 1
        run_op("sub",     2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 1'b0);
        run_op("add_i",   2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 1, 32'd12, 1'b0);
        run_op("sra",     2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'd4, 1, 32'hF800_0000, 1'b0);
        run_op("srl",     2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd4, 1, 32'h0800_0000, 1'b0);
        run_op("add00",   2'b00, 3'b111, 1'b1, 1'b0, 1'b1, 32'd3, 32'hFFFF_FFFD, 1, 32'd0, 1'b0);
        run_op("sub01",   2'b01, 3'b111, 1'b0, 1'b0, 1'b0, 32'd10, 32'd3, 1, 32'd7, 1'b0);
        run_op("add00m",  2'b00, 3'b000, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7, 1, 32'd13, 1'b0);
        run_op("slt",     2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 1'b0);
        run_op("sltu",    2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1'b0);
        run_op("sll",     2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'd1, 32'h25, 1, 32'h20, 1'b0);
        run_op("xor",     2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'h0FF0_0FF0, 1'b0);
        run_op("or",      2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hFFF0_FFF0, 1'b0);
        run_op("and",     2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 1'b0);

        // Multiplies, latency 33
        run_op("mul",     2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd3, 33, 32'hFFFF_FFFD, 1'b0);
        run_op("mulh",    2'b10, 3'b001, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 33, 32'hFFFF_FFFF, 1'b1);
        run_op("mulhsu",  2'b10, 3'b010, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 1'b0);
        run_op("mulhu",   2'b10, 3'b011, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 33, 32'd1, 1'b0);

        // Divides
        run_op("div",     2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 1'b0);
        run_op("rem",     2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 1'b0);
        run_op("div_nb",  2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_nb",  2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 1'b0);
        run_op("remu",    2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 33, 32'd2, 1'b0);
        run_op("divu_big",2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 1'b0);
        run_op("div_by0", 2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd7, 32'd0, 1, 32'hFFFF_FFFF, 1'b0);
        run_op("remu_by0",2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd9, 32'd0, 1, 32'd9, 1'b0);
        run_op("rem_ovf", 2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 1'b0);
        run_op("div_ovf", 2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0);

        // divu held by out_ready=0, then back-to-back add
        issue(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
        bus.out_ready = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("hold latency", lat, 33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold result",    bus.result,             32'd14);
            check("hold in_ready",  {31'd0, bus.in_ready},  32'd0);
            check("hold out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd20, 32'd22);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("b2b in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("b2b out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("b2b result",    bus.result,             32'd42);

        // reset in the middle of a mul
        issue(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        check("mid busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("abort busy",      {31'd0, bus.busy},      32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid === 1'b1) seen++;
            @(posedge clk);
            #1;
        end
        check("abort out_valid_seen", seen, 0);
        run_op("sltu_post", 2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, 1, 32'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
